// File: rtl/counter_snapshot_pkg.sv
// rtl/counter_snapshot_pkg.sv - shared FSM states and constants for the counter snapshot reader
package counter_snapshot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2
  } state_t;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;
  localparam int         DEF_WIDTH    = 16;
  localparam int         DEF_NUM_CH   = 8;
  localparam int         DEF_IDX_W    = 4;

endpackage

// File: rtl/counter_snapshot_reader_if.sv
// rtl/counter_snapshot_reader_if.sv - valid/ready word stream carrying snapshot words
interface counter_snapshot_reader_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) ();

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/counter_snapshot_bank.sv
// rtl/counter_snapshot_bank.sv - snapshot register file with load-all strobe and indexed read
// Optional XOR checksum register built when SNAPSHOT_CHECKSUM_EN is defined.
module counter_snapshot_bank #(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [NUM_CH*WIDTH-1:0] cnt_in,
  input  logic [IDX_W-1:0]        rd_idx,
`ifdef SNAPSHOT_CHECKSUM_EN
  output logic [WIDTH-1:0]        csum,
`endif
  output logic [WIDTH-1:0]        rd_data
);

  logic [WIDTH-1:0] snap [NUM_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) snap[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM_CH; k++) snap[k] <= cnt_in[k*WIDTH +: WIDTH];
    end
  end

  // Compare-based mux so out-of-range indices read zero without a wide array index.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_idx == IDX_W'(k)) rd_data = snap[k];
    end
  end

`ifdef SNAPSHOT_CHECKSUM_EN
  logic [WIDTH-1:0] csum_next;

  always_comb begin
    csum_next = '0;
    for (int k = 0; k < NUM_CH; k++) csum_next = csum_next ^ cnt_in[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     csum <= '0;
    else if (load) csum <= csum_next;
  end
`endif

endmodule

// File: rtl/counter_snapshot_reader.sv
// rtl/counter_snapshot_reader.sv - atomic capture of NUM_CH counters streamed out one word per transfer
// SNAPSHOT_CHECKSUM_EN appends an XOR checksum word after the last channel.
module counter_snapshot_reader
  import counter_snapshot_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*WIDTH-1:0]    cnt_in,
  input  logic                       capture_req,
  output logic                       busy,
  output logic                       capture_drop,
  output logic [7:0]                 drop_count,
  counter_snapshot_reader_if.master  stream
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             last_q;
  logic             load;
  logic             xfer;

  assign load   = (state == ST_IDLE) && capture_req;
  assign xfer   = valid_q && stream.out_ready;
  assign rd_idx = idx + IDX_W'(1);

`ifdef SNAPSHOT_CHECKSUM_EN
  logic [WIDTH-1:0] csum;
`endif

  counter_snapshot_bank #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .cnt_in  (cnt_in),
    .rd_idx  (rd_idx),
`ifdef SNAPSHOT_CHECKSUM_EN
    .csum    (csum),
`endif
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy         <= 1'b0;
      capture_drop <= 1'b0;
      drop_count   <= '0;
    end else begin
      // Any request outside IDLE is refused, including the final-transfer cycle.
      capture_drop <= capture_req && (state != ST_IDLE);
      if (capture_req && (state != ST_IDLE) && (drop_count != DROP_CNT_MAX))
        drop_count <= drop_count + 8'd1;

      case (state)
        ST_IDLE: begin
          if (capture_req) begin
            state   <= ST_SEND;
            busy    <= 1'b1;
            valid_q <= 1'b1;
            idx     <= '0;
            data_q  <= cnt_in[WIDTH-1:0];
            last_q  <= 1'b0;
          end
        end

        ST_SEND: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
`ifdef SNAPSHOT_CHECKSUM_EN
              state  <= ST_CSUM;
              idx    <= IDX_W'(NUM_CH);
              data_q <= csum;
              last_q <= 1'b1;
`else
              state   <= ST_IDLE;
              busy    <= 1'b0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              idx     <= '0;
`endif
            end else begin
              idx    <= rd_idx;
              data_q <= rd_data;
`ifdef SNAPSHOT_CHECKSUM_EN
              last_q <= 1'b0;
`else
              last_q <= (rd_idx == LAST_IDX);
`endif
            end
          end
        end

`ifdef SNAPSHOT_CHECKSUM_EN
        ST_CSUM: begin
          if (xfer) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx     <= '0;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stream.out_valid = valid_q;
  assign stream.out_data  = data_q;
  assign stream.out_idx   = idx;
  assign stream.out_last  = last_q;

endmodule

// File: tb/tb_counter_snapshot_reader.sv
// tb/tb_counter_snapshot_reader.sv - table-driven and directed checks for counter_snapshot_reader
module tb_counter_snapshot_reader;

  localparam int NUM_CH = 8;
  localparam int WIDTH  = 16;
  localparam int IDX_W  = 4;
`ifdef SNAPSHOT_CHECKSUM_EN
  localparam int NWORDS = 9;
`else
  localparam int NWORDS = 8;
`endif

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_CH*WIDTH-1:0] cnt_in = '0;
  logic                    capture_req = 1'b0;
  logic                    busy;
  logic                    capture_drop;
  logic [7:0]              drop_count;

  int checks = 0;
  int errors = 0;

  counter_snapshot_reader_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) sif ();

  counter_snapshot_reader #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH),
    .IDX_W  (IDX_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cnt_in       (cnt_in),
    .capture_req  (capture_req),
    .busy         (busy),
    .capture_drop (capture_drop),
    .drop_count   (drop_count),
    .stream       (sif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cap;
    logic        rdy;
    logic        frz;
    logic        e_busy;
    logic        e_valid;
    logic        e_last;
    logic        e_drop;
    logic [15:0] e_data;
    logic [3:0]  e_idx;
    logic [7:0]  e_dcnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic cap, rdy, frz, e_busy, e_valid, e_last, e_drop,
                              input logic [15:0] e_data, input logic [3:0] e_idx,
                              input logic [7:0] e_dcnt);
    vec_t v;
    v.cap = cap; v.rdy = rdy; v.frz = frz;
    v.e_busy = e_busy; v.e_valid = e_valid; v.e_last = e_last; v.e_drop = e_drop;
    v.e_data = e_data; v.e_idx = e_idx; v.e_dcnt = e_dcnt;
    return v;
  endfunction

  // mode 0: ch k = k+1, mode 1: all FFFF, mode 2: checksum pattern
  function automatic logic [NUM_CH*WIDTH-1:0] cnt_val(input int mode);
    logic [NUM_CH*WIDTH-1:0] v;
    logic [15:0] pat [4];
    pat[0] = 16'h00F0; pat[1] = 16'h0F00; pat[2] = 16'hF000; pat[3] = 16'h000F;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (mode == 0)      v[k*WIDTH +: WIDTH] = 16'(k + 1);
      else if (mode == 1) v[k*WIDTH +: WIDTH] = 16'hFFFF;
      else                v[k*WIDTH +: WIDTH] = (k < 4) ? pat[k] : 16'h0000;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    capture_req = 1'b0;
    sif.out_ready = 1'b0;
    cnt_in = cnt_val(0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("%s[%0d].valid", tag, i), 32'(sif.out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("%s[%0d].last", tag, i), 32'(sif.out_last), 32'(tbl[i].e_last));
      chk($sformatf("%s[%0d].drop", tag, i), 32'(capture_drop), 32'(tbl[i].e_drop));
      chk($sformatf("%s[%0d].dcnt", tag, i), 32'(drop_count), 32'(tbl[i].e_dcnt));
      if (tbl[i].e_valid) begin
        chk($sformatf("%s[%0d].data", tag, i), 32'(sif.out_data), 32'(tbl[i].e_data));
        chk($sformatf("%s[%0d].idx", tag, i), 32'(sif.out_idx), 32'(tbl[i].e_idx));
      end
      capture_req   = tbl[i].cap;
      sif.out_ready = tbl[i].rdy;
      cnt_in        = cnt_val(tbl[i].frz ? 1 : 0);
    end
    capture_req = 1'b0;
  endtask

  initial begin
    sif.out_ready = 1'b0;
    #1;
    chk("reset.busy", 32'(busy), 0);
    chk("reset.valid", 32'(sif.out_valid), 0);
    chk("reset.data", 32'(sif.out_data), 0);
    chk("reset.dcnt", 32'(drop_count), 0);

`ifndef SNAPSHOT_CHECKSUM_EN
    // basic read, out_ready held high
    do_reset();
    tbl.delete();
    tbl.push_back(mk(1,1,0, 0,0,0,0, 16'h0000,4'd0,8'd0));
    tbl.push_back(mk(0,1,0, 1,1,0,0, 16'h0001,4'd0,8'd0));
    tbl.push_back(mk(0,1,0, 1,1,0,0, 16'h0002,4'd1,8'd0));
    tbl.push_back(mk(0,1,0, 1,1,0,0, 16'h0003,4'd2,8'd0));
    tbl.push_back(mk(0,1,0, 1,1,0,0, 16'h0004,4'd3,8'd0));
    tbl.push_back(mk(0,1,0, 1,1,0,0, 16'h0005,4'd4,8'd0));
    tbl.push_back(mk(0,1,0, 1,1,0,0, 16'h0006,4'd5,8'd0));
    tbl.push_back(mk(0,1,0, 1,1,0,0, 16'h0007,4'd6,8'd0));
    tbl.push_back(mk(0,1,0, 1,1,1,0, 16'h0008,4'd7,8'd0));
    tbl.push_back(mk(0,1,0, 0,0,0,0, 16'h0000,4'd0,8'd0));
    run_tbl("basic");

    // backpressure 1,0,0,1 with frozen inputs and three refused requests
    do_reset();
    tbl.delete();
    tbl.push_back(mk(1,1,0, 0,0,0,0, 16'h0000,4'd0,8'd0));
    tbl.push_back(mk(0,1,1, 1,1,0,0, 16'h0001,4'd0,8'd0));
    tbl.push_back(mk(0,0,1, 1,1,0,0, 16'h0002,4'd1,8'd0));
    tbl.push_back(mk(1,0,1, 1,1,0,0, 16'h0002,4'd1,8'd0));
    tbl.push_back(mk(0,1,1, 1,1,0,1, 16'h0002,4'd1,8'd1));
    tbl.push_back(mk(0,1,1, 1,1,0,0, 16'h0003,4'd2,8'd1));
    tbl.push_back(mk(0,0,1, 1,1,0,0, 16'h0004,4'd3,8'd1));
    tbl.push_back(mk(1,0,1, 1,1,0,0, 16'h0004,4'd3,8'd1));
    tbl.push_back(mk(0,1,1, 1,1,0,1, 16'h0004,4'd3,8'd2));
    tbl.push_back(mk(0,1,1, 1,1,0,0, 16'h0005,4'd4,8'd2));
    tbl.push_back(mk(0,0,1, 1,1,0,0, 16'h0006,4'd5,8'd2));
    tbl.push_back(mk(0,0,1, 1,1,0,0, 16'h0006,4'd5,8'd2));
    tbl.push_back(mk(0,1,1, 1,1,0,0, 16'h0006,4'd5,8'd2));
    tbl.push_back(mk(0,1,1, 1,1,0,0, 16'h0007,4'd6,8'd2));
    tbl.push_back(mk(0,0,1, 1,1,1,0, 16'h0008,4'd7,8'd2));
    tbl.push_back(mk(0,0,1, 1,1,1,0, 16'h0008,4'd7,8'd2));
    tbl.push_back(mk(1,1,1, 1,1,1,0, 16'h0008,4'd7,8'd2));
    tbl.push_back(mk(0,1,1, 0,0,0,1, 16'h0000,4'd0,8'd3));
    tbl.push_back(mk(0,1,1, 0,0,0,0, 16'h0000,4'd0,8'd3));
    run_tbl("bp");
`else
    // checksum word follows channel 7
    do_reset();
    cnt_in = cnt_val(2);
    capture_req = 1'b1;
    sif.out_ready = 1'b1;
    @(negedge clk);
    capture_req = 1'b0;
    begin
      logic [15:0] exp_w [9];
      exp_w[0] = 16'h00F0; exp_w[1] = 16'h0F00; exp_w[2] = 16'hF000; exp_w[3] = 16'h000F;
      exp_w[4] = 16'h0000; exp_w[5] = 16'h0000; exp_w[6] = 16'h0000; exp_w[7] = 16'h0000;
      exp_w[8] = 16'hFFFF;
      for (int w = 0; w < 9; w++) begin
        chk($sformatf("csum[%0d].valid", w), 32'(sif.out_valid), 1);
        chk($sformatf("csum[%0d].idx", w), 32'(sif.out_idx), 32'(w));
        chk($sformatf("csum[%0d].data", w), 32'(sif.out_data), 32'(exp_w[w]));
        chk($sformatf("csum[%0d].last", w), 32'(sif.out_last), (w == 8) ? 1 : 0);
        @(negedge clk);
      end
    end
    chk("csum.end.valid", 32'(sif.out_valid), 0);
    chk("csum.end.busy", 32'(busy), 0);
`endif

    // 300 refused requests saturate the drop counter
    do_reset();
    capture_req = 1'b1;
    sif.out_ready = 1'b0;
    repeat (301) @(negedge clk);
    chk("sat.dcnt", 32'(drop_count), 255);
    chk("sat.drop", 32'(capture_drop), 1);
    chk("sat.idx", 32'(sif.out_idx), 0);
    chk("sat.data", 32'(sif.out_data), 16'h0001);
    // level-held request: refused on final transfer, accepted after one idle cycle
    sif.out_ready = 1'b1;
    repeat (NWORDS) @(negedge clk);
    chk("level.idle.busy", 32'(busy), 0);
    chk("level.idle.drop", 32'(capture_drop), 1);
    @(negedge clk);
    chk("level.recap.busy", 32'(busy), 1);
    chk("level.recap.idx", 32'(sif.out_idx), 0);
    chk("level.recap.data", 32'(sif.out_data), 16'h0001);
    capture_req = 1'b0;

    // reset mid-stream at idx 3
    do_reset();
    capture_req = 1'b1;
    sif.out_ready = 1'b1;
    @(negedge clk);
    capture_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid.idx", 32'(sif.out_idx), 3);
    chk("mid.data", 32'(sif.out_data), 16'h0004);
    reset = 1'b1;
    #1;
    chk("rst.valid", 32'(sif.out_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.idx", 32'(sif.out_idx), 0);
    chk("rst.data", 32'(sif.out_data), 0);
    chk("rst.last", 32'(sif.out_last), 0);
    @(negedge clk);
    reset = 1'b0;
    capture_req = 1'b1;
    @(negedge clk);
    capture_req = 1'b0;
    chk("restart.valid", 32'(sif.out_valid), 1);
    chk("restart.idx", 32'(sif.out_idx), 0);
    chk("restart.data", 32'(sif.out_data), 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_snapshot_reader.md
Name: counter_snapshot_reader

Overview:
- Sits directly downstream of the multi-clock 16-bit up-counter bank.
- Consumes NUM_CH counter values, all already synchronous to clk.
- On a capture request, atomically latches every channel in one cycle, then streams the frozen values out one word per transfer over a valid/ready handshake.
- Lets a host or debug interface read a coherent set of counter values.

Parameters:
- NUM_CH, 8, number of counter channels captured per snapshot (2..16).
- WIDTH, 16, bit width of each counter value and of out_data.
- IDX_W, 4, width of out_idx; must satisfy 2**IDX_W > NUM_CH.

Ports:
- clk  input  1  single clock; all logic is posedge.
- reset  input  1  asynchronous, active-high reset.
- cnt_in  input  NUM_CH*WIDTH  packed counter values; channel k is bits [k*WIDTH +: WIDTH].
- capture_req  input  1  single-cycle or level request to take a snapshot.
- busy  output  1  high from the capture cycle until the last word is accepted.
- out_valid  output  1  out_data/out_idx hold a word for transfer.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- out_data  output  WIDTH  captured counter value.
- out_idx  output  IDX_W  channel index of out_data.
- out_last  output  1  high with the final word of a snapshot.
- capture_drop  output  1  one-cycle pulse when capture_req is refused.
- drop_count  output  8  saturating count of refused requests.

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE; busy, out_valid, out_last, capture_drop = 0; out_data, out_idx, drop_count = 0; snapshot registers = 0.
- FSM states: IDLE, SEND (plus CSUM when the optional feature is enabled).
- IDLE with capture_req=1:
  - All NUM_CH words latch from cnt_in at that edge.
  - Next state is SEND.
  - On the following cycle: busy=1, out_valid=1, out_idx=0, out_data=snap[0].
  - Latency is 1 cycle from request to first valid word.
- SEND:
  - A word is transferred on any cycle with out_valid && out_ready.
  - On transfer with idx < NUM_CH-1: idx increments and out_data = snap[idx+1] on the next cycle. Back-to-back transfers run at one word per cycle.
  - While out_valid && !out_ready, out_data, out_idx and out_last must hold stable.
  - out_valid never drops inside SEND without a transfer.
  - out_last = 1 exactly when idx == NUM_CH-1 (and the optional feature is off).
  - Transfer of the last word: next state IDLE; out_valid, busy, out_last = 0 on the next cycle.
- capture_req while busy, including the cycle the last word transfers:
  - The request is ignored; the snapshot is not modified.
  - capture_drop pulses for one cycle.
  - drop_count increments, saturating at 255.
  - A level-held request is re-evaluated each cycle; after returning to IDLE it is accepted on the next cycle.
- Snapshot registers change only on an accepted capture; cnt_in activity during SEND has no effect.
- Reset mid-stream aborts immediately: all outputs return to reset values; no partial snapshot is retained.
- No arithmetic on data except the optional checksum.

Optional Feature:
- Macro: SNAPSHOT_CHECKSUM_EN.
- Defined:
  - After channel NUM_CH-1 is accepted, FSM enters CSUM and presents one extra word: out_data = XOR of all captured words, out_idx = NUM_CH, out_last = 1.
  - out_last is 0 on channel NUM_CH-1.
  - The checksum is computed at capture time into a register.
  - CSUM obeys the same hold/handshake rules; its transfer returns the FSM to IDLE.
- Undefined: no CSUM state and no checksum register; behaviour as above.

Decomposition:
- Package counter_snapshot_pkg: FSM state enum (ST_IDLE, ST_SEND, ST_CSUM), DROP_CNT_MAX = 8'hFF, default WIDTH/NUM_CH constants.
- One sub-module, counter_snapshot_bank:
  - NUM_CH x WIDTH register file with a load-all strobe and indexed read mux.
  - Optional XOR checksum register.
- Top level holds the FSM, the index counter and the drop counter.

Test Plan:
- Basic read: cnt_in ch0..7 = 16'h0001..16'h0008; capture_req pulse; out_ready=1 -> 8 consecutive words 0001..0008, idx 0..7, out_last only on idx 7, busy low one cycle after.
- Backpressure: out_ready toggles 1,0,0,1 per cycle during stream -> each word held stable while out_ready=0; no word skipped or duplicated; total 8 transfers.
- Capture freeze: change cnt_in to 16'hFFFF on all channels right after capture -> streamed values remain the pre-capture values.
- Drop: capture_req on the final-transfer cycle and twice mid-stream -> capture_drop pulses 3 times, drop_count = 3, snapshot unchanged; 300 drops -> drop_count = 255.
- Reset mid-stream: assert reset during idx 3 -> out_valid, busy, out_idx, out_data = 0 asynchronously; new capture after release restarts at idx 0.
- With SNAPSHOT_CHECKSUM_EN, data 16'h00F0,16'h0F00,16'hF000,16'h000F,0,0,0,0 -> 9th word 16'hFFFF, idx 8, out_last on the 9th word only.
